// File: rtl/ws_uart_rx.sv
// Mid-bit sampling 8N1 serial receiver with a 1-entry valid/ready holding register.
// Define WS_UART_RX_PARITY_EN for 8E1 framing with a live parity_err_o.
`timescale 1ns/1ps
module ws_uart_rx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk_in,
   input  logic       reset_in,
   input  logic       rxd_in,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_in,
   output logic       busy_o,
   output logic       frame_err_o,
   output logic       overrun_o,
   output logic       parity_err_o
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef WS_UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sync_p0;
   logic                   rxs;
   logic                   rxs_p1;
   logic [CNT_W-1:0]       bitcnt;
   logic [2:0]             idx;
   logic [7:0]             shreg;
   logic                   tick;
   logic                   ld_half, ld_full, shift_en, commit, ferr;

   // Input synchronizer; rxs_p1 is the previous synchronized sample for edge detection
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         sync_p0 <= '1;
         rxs_p1  <= 1'b1;
      end else begin
         sync_p0 <= {sync_p0[SYNC_STAGES-2:0], rxd_in};
         rxs_p1  <= rxs;
      end
   end

   assign rxs  = sync_p0[SYNC_STAGES-1];
   assign tick = (bitcnt == '0);

   always_ff @(posedge clk_in) begin
      if (reset_in) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

`ifdef WS_UART_RX_PARITY_EN
   logic par_ld;
   logic par_bad;
`endif

   always_comb begin
      state_d  = state_q;
      ld_half  = 1'b0;
      ld_full  = 1'b0;
      shift_en = 1'b0;
      commit   = 1'b0;
      ferr     = 1'b0;
`ifdef WS_UART_RX_PARITY_EN
      par_ld   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (rxs_p1 && !rxs) begin
               ld_half = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               if (rxs) begin
                  state_d = S_IDLE;
               end else begin
                  ld_full = 1'b1;
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               shift_en = 1'b1;
               ld_full  = 1'b1;
`ifdef WS_UART_RX_PARITY_EN
               if (idx == 3'd7) state_d = S_PARITY;
`else
               if (idx == 3'd7) state_d = S_STOP;
`endif
            end
         end
`ifdef WS_UART_RX_PARITY_EN
         S_PARITY: begin
            if (tick) begin
               par_ld  = 1'b1;
               ld_full = 1'b1;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               if (rxs) begin
                  commit  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr    = 1'b1;
                  state_d = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (rxs) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         bitcnt <= '0;
         idx    <= '0;
      end else begin
         if (ld_half)            bitcnt <= HALF_RELOAD;
         else if (ld_full)       bitcnt <= FULL_RELOAD;
         else if (!tick)         bitcnt <= bitcnt - 1'b1;

         if (state_q == S_START) idx <= '0;
         else if (shift_en)      idx <= idx + 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (shift_en) shreg <= {rxs, shreg[7:1]};
   end

`ifdef WS_UART_RX_PARITY_EN
   // Even parity: the parity bit must equal the XOR of the eight data bits
   always_ff @(posedge clk_in) begin
      if (par_ld) par_bad <= (rxs != (^shreg));
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) parity_err_o <= 1'b0;
      else          parity_err_o <= commit && par_bad;
   end
`else
   assign parity_err_o = 1'b0;
`endif

   // Holding register: a commit may coincide with an accept and still land
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         data_o      <= '0;
         valid_o     <= 1'b0;
         overrun_o   <= 1'b0;
         frame_err_o <= 1'b0;
      end else begin
         overrun_o   <= 1'b0;
         frame_err_o <= ferr;
         if (commit) begin
            if (!valid_o || ready_in) begin
               data_o  <= shreg;
               valid_o <= 1'b1;
            end else begin
               overrun_o <= 1'b1;
            end
         end else if (valid_o && ready_in) begin
            valid_o <= 1'b0;
         end
      end
   end

   assign busy_o = (state_q != S_IDLE);

endmodule
